uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 8700, clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL provide parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have port i_clock, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port i_tx_dv, input, 1, byte-valid request from the user.
REQ-006 SHALL have port i_tx_byte, input, 8, byte to send; sampled only on acceptance.
REQ-007 SHALL have port o_tx_ready, output, 1, holding register empty; a byte can be accepted.
REQ-008 SHALL have port o_tx_serial, output, 1, serial line; idles high.
REQ-009 SHALL have port o_tx_active, output, 1, high while a frame (start to stop bit) is on the line.
REQ-010 SHALL have port o_tx_done, output, 1, one-cycle pulse at the end of each frame's stop bit.

Function
REQ-011 SHALL accept a byte on a rising edge where i_tx_dv=1 and o_tx_ready=1, storing it in a one-entry holding register; i_tx_dv while o_tx_ready=0 SHALL be ignored, with no byte lost or duplicated.
REQ-012 SHALL drive o_tx_ready combinationally as NOT(holding-register-valid).
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY=0.
REQ-014 In IDLE with the holding register valid, the next edge SHALL enter START, move the byte into the shift register, clear holding-valid, drive o_tx_serial=0 and o_tx_active=1.
REQ-015 Latency: for a byte accepted at edge k while IDLE, o_tx_serial SHALL fall at edge k+1.
REQ-016 Each bit (start, data, parity, stop) SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter of width clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1 and clears on each bit boundary.
REQ-017 DATA SHALL send 8 bits LSB first, using a 3-bit index that advances 0..7 and wraps to 0 on leaving DATA.
REQ-018 PARITY SHALL drive the XOR of the 8 data bits for even parity, or its inverse for odd parity.
REQ-019 STOP SHALL drive o_tx_serial=1.
REQ-020 At the last STOP cycle the next edge SHALL pulse o_tx_done=1 for exactly one cycle.
REQ-021 At that same edge, if holding-valid=1 the FSM SHALL enter START directly (back-to-back, zero idle cycles, o_tx_active stays 1); otherwise it SHALL enter IDLE with o_tx_active=0.
REQ-022 A byte SHALL be acceptable at any time the holding register is empty, including during a frame and in the cycle the holding register empties (REQ-014).
REQ-023 Frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-024 All outputs except o_tx_ready SHALL be registered; o_tx_serial SHALL be glitch-free.
REQ-025 An illegal state encoding SHALL return to IDLE on the next edge with o_tx_serial=1.

Reset
REQ-026 When i_reset_n=0 at an edge, outputs SHALL be: o_tx_serial=1, o_tx_active=0, o_tx_done=0, o_tx_ready=1; state IDLE; counters, index and holding-valid cleared.
REQ-027 Reset asserted mid-frame SHALL abort the frame: the line is high at the next edge, no o_tx_done pulse, and a pending held byte is discarded.
REQ-028 i_tx_dv SHALL be ignored in any cycle where i_reset_n=0.

Verification (CLKS_PER_BIT=8)
REQ-029 PARITY=0, send 0xA5 while idle -> serial low at k+1; bits 1,0,1,0,0,1,0,1 at 8 cycles each; stop high; o_tx_done pulse at k+81; o_tx_active high for 80 cycles.
REQ-030 PARITY=0, send 0x3C, then assert i_tx_dv with 0xC3 during the first frame -> o_tx_ready low until the second byte moves to the shift register; second start bit immediately follows the first stop bit; total 160 active cycles; two done pulses.
REQ-031 Hold i_tx_dv=1 continuously with changing data while o_tx_ready=0 -> exactly one extra byte is captured, namely the value present on the accepting edge.
REQ-032 PARITY=1 with 0x07 -> parity bit 1; PARITY=2 with 0x07 -> parity bit 0; frame 88 cycles.
REQ-033 Reset asserted at cycle 30 of a frame with a byte held -> serial=1, ready=1, active=0 after that edge; no done pulse; no further frame.
REQ-034 CLKS_PER_BIT=2, PARITY=0, back-to-back 0x00 and 0xFF -> exact 20-cycle frames with no gap between them.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// UART transmitter with a one-entry holding register in front of the frame FSM.
// Supports optional even/odd parity and back-to-back frames with no idle gap.
module uart_tx_buffered #(
   parameter int CLKS_PER_BIT = 8700,
   parameter int PARITY       = 0
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic       i_tx_dv,
   input  logic [7:0] i_tx_byte,
   output logic       o_tx_ready,
   output logic       o_tx_serial,
   output logic       o_tx_active,
   output logic       o_tx_done
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       hold_q;
   logic             hold_valid_q, hold_valid_d;
   logic             serial_q, serial_d;
   logic             active_q, active_d;
   logic             done_q, done_d;
   logic             bit_end, load, accept, parity_bit;

   assign accept     = i_tx_dv && !hold_valid_q;
   assign bit_end    = (cnt_q == CNT_LAST);
   assign parity_bit = (PARITY == 2) ? ~(^shift_q) : ^shift_q;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d  = state_q;
      cnt_d    = bit_end ? '0 : cnt_q + CNT_W'(1);
      idx_d    = idx_q;
      serial_d = serial_q;
      active_d = active_q;
      done_d   = 1'b0;
      load     = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d    = '0;
            idx_d    = '0;
            serial_d = 1'b1;
            active_d = 1'b0;
            if (hold_valid_q) begin
               load     = 1'b1;
               state_d  = S_START;
               serial_d = 1'b0;
               active_d = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d  = S_DATA;
               serial_d = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == 3'd7) begin
                  idx_d = '0;
                  if (PARITY != 0) begin
                     state_d  = S_PARITY;
                     serial_d = parity_bit;
                  end else begin
                     state_d  = S_STOP;
                     serial_d = 1'b1;
                  end
               end else begin
                  idx_d    = idx_q + 3'd1;
                  serial_d = shift_q[idx_d];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d  = S_STOP;
               serial_d = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               done_d = 1'b1;
               // A held byte chains straight into the next start bit.
               if (hold_valid_q) begin
                  load     = 1'b1;
                  state_d  = S_START;
                  serial_d = 1'b0;
               end else begin
                  state_d  = S_IDLE;
                  serial_d = 1'b1;
                  active_d = 1'b0;
               end
            end
         end
         default: begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            idx_d    = '0;
            serial_d = 1'b1;
            active_d = 1'b0;
         end
      endcase

      shift_d = load ? hold_q : shift_q;

      hold_valid_d = hold_valid_q;
      if (load)        hold_valid_d = 1'b0;
      else if (accept) hold_valid_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         hold_valid_q <= 1'b0;
         serial_q     <= 1'b1;
         active_q     <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         hold_valid_q <= hold_valid_d;
         serial_q     <= serial_d;
         active_q     <= active_d;
         done_q       <= done_d;
      end
   end

   // NOTE: data-only registers carry no reset; hold_valid_q and the FSM state qualify their contents.
   always_ff @(posedge i_clock) begin
      shift_q <= shift_d;
      if (accept) hold_q <= i_tx_byte;
   end

   assign o_tx_ready  = ~hold_valid_q;
   assign o_tx_serial = serial_q;
   assign o_tx_active = active_q;
   assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: four instances (no parity, even, odd, 2 clocks/bit),
// a per-channel frame decoder and a scoreboard of expected bytes.
module tb_uart_tx_buffered;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] dv, ready, serial, active, done;
   logic [7:0] din [4];
   int         cyc   = 0;
   int         total = 0;
   int         bad   = 0;
   logic [7:0] q0[$], q1[$], q2[$], q3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_buffered #(.CLKS_PER_BIT(8), .PARITY(0)) dut0 (
      .i_clock(clk), .i_reset_n(rst_n), .i_tx_dv(dv[0]), .i_tx_byte(din[0]),
      .o_tx_ready(ready[0]), .o_tx_serial(serial[0]), .o_tx_active(active[0]), .o_tx_done(done[0]));
   uart_tx_buffered #(.CLKS_PER_BIT(8), .PARITY(1)) dut1 (
      .i_clock(clk), .i_reset_n(rst_n), .i_tx_dv(dv[1]), .i_tx_byte(din[1]),
      .o_tx_ready(ready[1]), .o_tx_serial(serial[1]), .o_tx_active(active[1]), .o_tx_done(done[1]));
   uart_tx_buffered #(.CLKS_PER_BIT(8), .PARITY(2)) dut2 (
      .i_clock(clk), .i_reset_n(rst_n), .i_tx_dv(dv[2]), .i_tx_byte(din[2]),
      .o_tx_ready(ready[2]), .o_tx_serial(serial[2]), .o_tx_active(active[2]), .o_tx_done(done[2]));
   uart_tx_buffered #(.CLKS_PER_BIT(2), .PARITY(0)) dut3 (
      .i_clock(clk), .i_reset_n(rst_n), .i_tx_dv(dv[3]), .i_tx_byte(din[3]),
      .o_tx_ready(ready[3]), .o_tx_serial(serial[3]), .o_tx_active(active[3]), .o_tx_done(done[3]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int ch, input logic [7:0] b);
      case (ch)
         0: q0.push_back(b);
         1: q1.push_back(b);
         2: q2.push_back(b);
         default: q3.push_back(b);
      endcase
   endtask

   task automatic pop_exp(input int ch, output logic [7:0] b, output logic ok);
      ok = 1'b0;
      b  = 8'h00;
      case (ch)
         0: if (q0.size() != 0) begin b = q0.pop_front(); ok = 1'b1; end
         1: if (q1.size() != 0) begin b = q1.pop_front(); ok = 1'b1; end
         2: if (q2.size() != 0) begin b = q2.pop_front(); ok = 1'b1; end
         default: if (q3.size() != 0) begin b = q3.pop_front(); ok = 1'b1; end
      endcase
   endtask

   function automatic int pending();
      return q0.size() + q1.size() + q2.size() + q3.size();
   endfunction

   // Waits for ready, offers one byte for one edge; acc is the accepting edge number.
   task automatic send(input int ch, input logic [7:0] b, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      while (ready[ch] !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("ch%0d_ready_for_%02h", ch, b), 32'(ready[ch]), 1);
      dv[ch]  = 1'b1;
      din[ch] = b;
      acc     = cyc + 1;
      push_exp(ch, b);
      @(negedge clk);
      dv[ch] = 1'b0;
   endtask

   task automatic run_window(input int ch, input int ncyc, output int act_cnt, output int done_cnt,
                             output int first_low, output int first_done, output int last_done,
                             output logic rdy_pre_done, output logic rdy_at_done);
      logic prev_rdy;
      act_cnt = 0; done_cnt = 0; first_low = -1; first_done = -1; last_done = -1;
      rdy_pre_done = 1'bx; rdy_at_done = 1'bx;
      prev_rdy = ready[ch];
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (active[ch] === 1'b1) act_cnt++;
         if (first_low < 0 && serial[ch] === 1'b0) first_low = cyc;
         if (done[ch] === 1'b1) begin
            if (done_cnt == 0) begin
               first_done   = cyc;
               rdy_pre_done = prev_rdy;
               rdy_at_done  = ready[ch];
            end
            last_done = cyc;
            done_cnt++;
         end
         prev_rdy = ready[ch];
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((pending() != 0 || active !== 4'h0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < 3000), 1);
      repeat (4) @(negedge clk);
   endtask

   // Frame decoder per channel: pops the expected byte at each start bit and
   // checks every cycle of the frame, the done pulse and chaining into the next frame.
   for (genvar g = 0; g < 4; g++) begin : g_mon
      localparam int CPB = (g == 3) ? 2 : 8;
      localparam int PM  = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
      localparam int NB  = (PM != 0) ? 11 : 10;
      initial begin : mon
         logic [10:0] bits;
         logic [7:0]  b;
         logic        ok, aborted, chained;
         int          bit_bad, act_bad, done_bad;
         chained = 1'b0;
         forever begin
            if (!chained) begin
               @(negedge clk);
               if (!(rst_n === 1'b1 && serial[g] === 1'b0)) continue;
            end
            pop_exp(g, b, ok);
            chk($sformatf("ch%0d_frame_expected", g), 32'(ok), 1);
            bits      = '1;
            bits[0]   = 1'b0;
            bits[8:1] = b;
            if (PM == 1) bits[9] = ^b;
            else if (PM == 2) bits[9] = ~^b;
            aborted = 1'b0; bit_bad = 0; act_bad = 0; done_bad = 0;
            for (int i = 0; i < NB * CPB && !aborted; i++) begin
               if (i > 0) @(negedge clk);
               if (rst_n !== 1'b1) aborted = 1'b1;
               else begin
                  if (serial[g] !== bits[i / CPB]) bit_bad++;
                  if (active[g] !== 1'b1) act_bad++;
                  if (done[g] !== ((i == 0) ? chained : 1'b0)) done_bad++;
               end
            end
            chained = 1'b0;
            if (aborted) continue;
            chk($sformatf("ch%0d_bits_%02h", g, b), 32'(bit_bad), 0);
            chk($sformatf("ch%0d_active_%02h", g, b), 32'(act_bad), 0);
            chk($sformatf("ch%0d_done_early_%02h", g, b), 32'(done_bad), 0);
            @(negedge clk);
            if (rst_n === 1'b1) begin
               chk($sformatf("ch%0d_done_pulse_%02h", g, b), 32'(done[g]), 1);
               if (serial[g] === 1'b0) chained = 1'b1;
               else chk($sformatf("ch%0d_idle_after_%02h", g, b), 32'(active[g]), 0);
            end
         end
      end
   end

   initial begin
      int          k, k2, kb, act, dn, fl, fd, ld, rise;
      int          act_b, dn_b, fl_b, fd_b, ld_b;
      logic        rp, ra, rp_b, ra_b, found;

      // Reset with dv asserted: requests must be ignored.
      rst_n = 1'b0;
      dv    = 4'hF;
      for (int i = 0; i < 4; i++) din[i] = 8'hEE;
      repeat (3) @(negedge clk);
      chk("rst_serial", 32'(serial), 32'hF);
      chk("rst_active", 32'(active), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ready", 32'(ready), 32'hF);
      rst_n = 1'b1;
      dv    = 4'h0;
      repeat (4) @(negedge clk);
      chk("post_rst_ready", 32'(ready), 32'hF);
      chk("post_rst_no_frame", 32'(active), 0);

      // Single byte from idle: latency, frame length, done timing.
      send(0, 8'hA5, k);
      chk("a5_ready_held", 32'(ready[0]), 0);
      chk("a5_line_high_at_k", 32'(serial[0]), 1);
      run_window(0, 100, act, dn, fl, fd, ld, rp, ra);
      chk("a5_start_edge", 32'(fl), 32'(k + 1));
      chk("a5_active_cycles", 32'(act), 80);
      chk("a5_done_count", 32'(dn), 1);
      chk("a5_done_edge", 32'(fd), 32'(k + 81));
      wait_idle("a5_drain");

      // Second byte offered mid-frame chains with no gap.
      send(0, 8'h3C, k);
      fork
         run_window(0, 200, act, dn, fl, fd, ld, rp, ra);
         begin
            repeat (20) @(negedge clk);
            send(0, 8'hC3, k2);
         end
      join
      chk("b2b_start_edge", 32'(fl), 32'(k + 1));
      chk("b2b_active_cycles", 32'(act), 160);
      chk("b2b_done_count", 32'(dn), 2);
      chk("b2b_first_done", 32'(fd), 32'(k + 81));
      chk("b2b_last_done", 32'(ld), 32'(k + 161));
      chk("b2b_ready_low_before_move", 32'(rp), 0);
      chk("b2b_ready_high_after_move", 32'(ra), 1);
      wait_idle("b2b_drain");

      // dv held with changing data while full: only the value on the accepting edge is taken.
      send(0, 8'h11, k);
      send(0, 8'h22, k2);
      dv[0]  = 1'b1;
      din[0] = 8'h40;
      found  = 1'b0;
      rise   = -1;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (ready[0] === 1'b1) begin
            found = 1'b1;
            rise  = cyc;
            push_exp(0, din[0]);
         end else begin
            din[0] = din[0] + 8'd1;
         end
      end
      @(negedge clk);
      dv[0] = 1'b0;
      chk("hold_dv_accepted", 32'(found), 1);
      chk("hold_dv_ready_rise", 32'(rise), 32'(k + 81));
      wait_idle("hold_dv_drain");

      // Even and odd parity on 0x07.
      fork
         begin
            send(1, 8'h07, k);
            run_window(1, 120, act, dn, fl, fd, ld, rp, ra);
         end
         begin
            send(2, 8'h07, kb);
            run_window(2, 120, act_b, dn_b, fl_b, fd_b, ld_b, rp_b, ra_b);
         end
      join
      chk("even_active_cycles", 32'(act), 88);
      chk("even_done_edge", 32'(fd), 32'(k + 89));
      chk("odd_active_cycles", 32'(act_b), 88);
      chk("odd_done_edge", 32'(fd_b), 32'(kb + 89));
      wait_idle("parity_drain");

      // Two clocks per bit, back-to-back 0x00 then 0xFF.
      send(3, 8'h00, k);
      fork
         run_window(3, 60, act, dn, fl, fd, ld, rp, ra);
         send(3, 8'hFF, k2);
      join
      chk("fast_start_edge", 32'(fl), 32'(k + 1));
      chk("fast_active_cycles", 32'(act), 40);
      chk("fast_done_count", 32'(dn), 2);
      chk("fast_first_done", 32'(fd), 32'(k + 21));
      chk("fast_last_done", 32'(ld), 32'(k + 41));
      wait_idle("fast_drain");

      // Reset mid-frame with a byte held: frame aborted, held byte discarded.
      send(0, 8'h5A, k);
      send(0, 8'h99, k2);
      while (cyc < k + 30) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_serial", 32'(serial[0]), 1);
      chk("abort_ready", 32'(ready[0]), 1);
      chk("abort_active", 32'(active[0]), 0);
      chk("abort_done", 32'(done[0]), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      q0.delete();
      run_window(0, 200, act, dn, fl, fd, ld, rp, ra);
      chk("abort_no_frame", 32'(act), 0);
      chk("abort_no_done", 32'(dn), 0);
      chk("abort_line_high", 32'(fl), 32'hFFFF_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
